// File: rtl/jtpang_pkg.sv
// Shared definitions for the pang-family colour mixer: parameter defaults and
// the palette read sequencer states.
package jtpang_pkg;

  localparam int         PXLW_DEF   = 11;
  localparam int         CW_DEF     = 4;
  localparam logic [3:0] TRANSP_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    CAP   = 2'd3
  } seq_e;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port byte RAM: port 0 read/write, port 1 read-only, registered reads
// returning the old contents when a write hits the same address.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic          clk1,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  // NOTE: storage has no reset; clearing a RAM would force it into flops.
  logic [dw-1:0] mem [0:2**aw-1];

  always_ff @(posedge clk0) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtpang_colmix_prio.sv
// Layer priority select: the lowest-numbered enabled opaque layer wins; the
// last layer is the backdrop when every layer is masked or transparent.
module jtpang_colmix_prio
  import jtpang_pkg::*;
#(
  parameter int         LAYERS = 2,
  parameter int         PXLW   = PXLW_DEF,
  parameter logic [3:0] TRANSP = TRANSP_DEF
) (
  input  logic [LAYERS*PXLW-1:0] lyr_pxl,
  input  logic [LAYERS-1:0]      lyr_en,
  output logic [PXLW-1:0]        sel_pxl
);

  // Scan from lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    sel_pxl = lyr_pxl[(LAYERS-1)*PXLW +: PXLW];
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (lyr_en[k] && (lyr_pxl[k*PXLW +: 4] != TRANSP)) begin
        sel_pxl = lyr_pxl[k*PXLW +: PXLW];
      end
    end
  end

endmodule

// File: rtl/jtpang_colmix_nl.sv
// N-layer colour mixer: priority select, two-byte palette fetch from dual-port
// RAM, one-pixel output latency with blanking, bank switch at vblank start.
module jtpang_colmix_nl
  import jtpang_pkg::*;
#(
  parameter int         LAYERS = 2,
  parameter int         PXLW   = PXLW_DEF,
  parameter int         CW     = CW_DEF,
  parameter int         BW     = 1,
  parameter logic [3:0] TRANSP = TRANSP_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] lyr_pxl,
  input  logic [LAYERS-1:0]      lyr_en,
  input  logic [BW-1:0]          pal_bank,
  input  logic                   pal_cs,
  input  logic                   wr_n,
  input  logic [PXLW:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly
);

  localparam int AW = PXLW + BW + 1;

  seq_e            st_q, st_d;
  logic [PXLW-1:0] sel_pxl, pal_a_q, pal_a_d;
  logic [BW-1:0]   bank_act_q, bank_act_d, bank_lat_q, bank_lat_d;
  logic            lvbl_last_q, lvbl_last_d;
  logic [7:0]      lo_q, lo_d;
  logic [15:0]     next_col_q, next_col_d;
  logic            hb_s_q, hb_s_d, vb_s_q, vb_s_d;
  logic            hb_dly_q, hb_dly_d, vb_dly_q, vb_dly_d;
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic [AW-1:0]   cpu_ram_a, vid_ram_a;
  logic [7:0]      vid_q;

  jtpang_colmix_prio #(
    .LAYERS (LAYERS),
    .PXLW   (PXLW),
    .TRANSP (TRANSP)
  ) u_prio (
    .lyr_pxl (lyr_pxl),
    .lyr_en  (lyr_en),
    .sel_pxl (sel_pxl)
  );

  assign cpu_ram_a = {cpu_addr[0], pal_bank, cpu_addr[PXLW:1]};
  assign vid_ram_a = {st_q == RD_HI, bank_lat_q, pal_a_q};

  jtframe_dual_ram #(
    .dw (8),
    .aw (AW)
  ) u_ram (
    .clk0  (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_ram_a),
    .we0   (pal_cs & ~wr_n),
    .q0    (pal_dout),
    .clk1  (clk),
    .addr1 (vid_ram_a),
    .q1    (vid_q)
  );

  // NOTE: every _d gets its hold value first so no path can infer a latch.
  always_comb begin
    st_d        = st_q;
    pal_a_d     = pal_a_q;
    bank_lat_d  = bank_lat_q;
    lo_d        = lo_q;
    next_col_d  = next_col_q;
    hb_s_d      = hb_s_q;
    vb_s_d      = vb_s_q;
    hb_dly_d    = hb_dly_q;
    vb_dly_d    = vb_dly_q;
    rgb_d       = rgb_q;
    lvbl_last_d = LVBL;
    bank_act_d  = (lvbl_last_q && !LVBL) ? pal_bank : bank_act_q;

    case (st_q)
      RD_LO:   st_d = RD_HI;
      RD_HI: begin
        lo_d = vid_q;
        st_d = CAP;
      end
      CAP: begin
        next_col_d = {vid_q, lo_q};
        st_d       = IDLE;
      end
      default: st_d = IDLE;
    endcase

    // A pixel arriving in CAP forwards the word being completed; earlier
    // arrivals restart the fetch and show the last complete word.
    if (pxl_cen) begin
      st_d       = RD_LO;
      pal_a_d    = sel_pxl;
      bank_lat_d = bank_act_q;
      hb_s_d     = LHBL;
      vb_s_d     = LVBL;
      hb_dly_d   = hb_s_q;
      vb_dly_d   = vb_s_q;
      rgb_d      = (hb_s_q && vb_s_q) ? next_col_d[3*CW-1:0] : '0;
    end
  end

  // NOTE: state registers use non-blocking assignments to avoid update races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      pal_a_q     <= '0;
      bank_act_q  <= '0;
      bank_lat_q  <= '0;
      lvbl_last_q <= 1'b0;
      lo_q        <= '0;
      next_col_q  <= '0;
      hb_s_q      <= 1'b0;
      vb_s_q      <= 1'b0;
      hb_dly_q    <= 1'b0;
      vb_dly_q    <= 1'b0;
      rgb_q       <= '0;
    end else begin
      st_q        <= st_d;
      pal_a_q     <= pal_a_d;
      bank_act_q  <= bank_act_d;
      bank_lat_q  <= bank_lat_d;
      lvbl_last_q <= lvbl_last_d;
      lo_q        <= lo_d;
      next_col_q  <= next_col_d;
      hb_s_q      <= hb_s_d;
      vb_s_q      <= vb_s_d;
      hb_dly_q    <= hb_dly_d;
      vb_dly_q    <= vb_dly_d;
      rgb_q       <= rgb_d;
    end
  end

  assign red      = rgb_q[3*CW-1:2*CW];
  assign green    = rgb_q[2*CW-1:CW];
  assign blue     = rgb_q[CW-1:0];
  assign LHBL_dly = hb_dly_q;
  assign LVBL_dly = vb_dly_q;

endmodule

// File: tb/tb_jtpang_colmix_nl.sv
// Bench for jtpang_colmix_nl: 3-layer mixers at CW=4 and CW=5 share stimulus
// and are compared against a palette/priority/bank model kept here.
module tb_jtpang_colmix_nl;

  localparam int LAYERS = 3;
  localparam int PXLW   = 11;
  localparam int BW     = 1;
  localparam int LW     = LAYERS * PXLW;

  logic              clk = 1'b0, rst_n = 1'b1, pxl_cen = 1'b0;
  logic              LHBL = 1'b1, LVBL = 1'b1, pal_cs = 1'b0, wr_n = 1'b1;
  logic [LW-1:0]     lyr_pxl = '0;
  logic [LAYERS-1:0] lyr_en = '1;
  logic [BW-1:0]     pal_bank = '0;
  logic [PXLW:0]     cpu_addr = '0;
  logic [7:0]        cpu_dout = '0;
  logic [7:0]        pal_dout4, pal_dout5;
  logic [3:0]        r4, g4, b4;
  logic [4:0]        r5, g5, b5;
  logic              hd4, vd4, hd5, vd5;

  always #5 clk = ~clk;

  jtpang_colmix_nl #(.LAYERS(LAYERS), .PXLW(PXLW), .CW(4), .BW(BW), .TRANSP(4'hF)) dut4 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .lyr_pxl(lyr_pxl), .lyr_en(lyr_en), .pal_bank(pal_bank), .pal_cs(pal_cs),
    .wr_n(wr_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout4),
    .red(r4), .green(g4), .blue(b4), .LHBL_dly(hd4), .LVBL_dly(vd4)
  );

  jtpang_colmix_nl #(.LAYERS(LAYERS), .PXLW(PXLW), .CW(5), .BW(BW), .TRANSP(4'hF)) dut5 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .lyr_pxl(lyr_pxl), .lyr_en(lyr_en), .pal_bank(pal_bank), .pal_cs(pal_cs),
    .wr_n(wr_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout5),
    .red(r5), .green(g5), .blue(b5), .LHBL_dly(hd5), .LVBL_dly(vd5)
  );

  // Reference model state
  logic [15:0] pal [2][2048];
  int          vecs = 0, errs = 0;
  int          model_bank, last_word, pend_word, prev_gap;
  bit          prev_hb, prev_vb, lvbl_prev;
  int          pool [16];

  typedef struct {
    logic [LW-1:0] p;
    logic [2:0]    en;
    bit            hb;
    bit            vb;
    int            entry;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] lp(input int a0, input int a1, input int a2);
    return {PXLW'(a2), PXLW'(a1), PXLW'(a0)};
  endfunction

  function automatic int prio(input logic [LW-1:0] p, input logic [2:0] en);
    for (int k = 0; k < LAYERS; k++)
      if (en[k] && p[k*PXLW +: 4] != 4'hF) return int'(p[k*PXLW +: PXLW]);
    return int'(p[(LAYERS-1)*PXLW +: PXLW]);
  endfunction

  // Channel pos: 0 = blue, 1 = green, 2 = red, each cw bits wide.
  function automatic int fld(input int w, input int cw, input int pos);
    return (w >> (pos * cw)) & ((1 << cw) - 1);
  endfunction

  task automatic model_reset();
    model_bank = 0;
    last_word  = 0;
    pend_word  = 0;
    prev_gap   = 4;
    prev_hb    = 1'b0;
    prev_vb    = 1'b0;
    lvbl_prev  = LVBL;
  endtask

  task automatic cpu_wr(input int bank, input int entry, input int data16);
    for (int b = 0; b < 2; b++) begin
      pal_bank = BW'(bank);
      cpu_addr = {PXLW'(entry), 1'(b)};
      cpu_dout = 8'(data16 >> (8 * b));
      pal_cs   = 1'b1;
      wr_n     = 1'b0;
      @(negedge clk);
      pal_cs   = 1'b0;
      wr_n     = 1'b1;
    end
    pal[bank][entry] = 16'(data16);
  endtask

  task automatic cpu_chk(input int bank, input int entry, input int b);
    pal_bank = BW'(bank);
    cpu_addr = {PXLW'(entry), 1'(b)};
    pal_cs   = 1'b1;
    wr_n     = 1'b1;
    @(negedge clk);
    check($sformatf("rd4 b%0d e%0h byte%0d", bank, entry, b), pal_dout4, 32'(pal[bank][entry] >> (8 * b)) & 32'hFF);
    check($sformatf("rd5 b%0d e%0h byte%0d", bank, entry, b), pal_dout5, 32'(pal[bank][entry] >> (8 * b)) & 32'hFF);
    pal_cs = 1'b0;
  endtask

  // Apply one pixel, check the previous pixel's colour, then idle gap-1 clocks.
  task automatic px(input logic [LW-1:0] p, input logic [2:0] en, input bit hb, input bit vb,
                    input int gap, input int exp_entry, input string tag);
    int entry;
    bit blank;
    if (prev_gap >= 3) last_word = pend_word;
    blank   = !(prev_hb && prev_vb);
    lyr_pxl = p;
    lyr_en  = en;
    LHBL    = hb;
    LVBL    = vb;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    check({tag, " red4"},   32'(r4), blank ? 0 : fld(last_word, 4, 2));
    check({tag, " green4"}, 32'(g4), blank ? 0 : fld(last_word, 4, 1));
    check({tag, " blue4"},  32'(b4), blank ? 0 : fld(last_word, 4, 0));
    check({tag, " red5"},   32'(r5), blank ? 0 : fld(last_word, 5, 2));
    check({tag, " green5"}, 32'(g5), blank ? 0 : fld(last_word, 5, 1));
    check({tag, " blue5"},  32'(b5), blank ? 0 : fld(last_word, 5, 0));
    check({tag, " hbl_dly"}, {30'd0, hd4, hd5}, {30'd0, prev_hb, prev_hb});
    check({tag, " vbl_dly"}, {30'd0, vd4, vd5}, {30'd0, prev_vb, prev_vb});
    entry     = (exp_entry >= 0) ? exp_entry : prio(p, en);
    pend_word = int'(pal[model_bank][entry]);
    if (lvbl_prev && !vb) model_bank = int'(pal_bank);
    lvbl_prev = vb;
    prev_hb   = hb;
    prev_vb   = vb;
    prev_gap  = gap;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " rgb4"}, {20'd0, r4, g4, b4}, 32'd0);
    check({tag, " rgb5"}, {17'd0, r5, g5, b5}, 32'd0);
    check({tag, " dly"},  {28'd0, hd4, vd4, hd5, vd5}, 32'd0);
  endtask

  initial begin
    #300000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before the first clock edge
    #1 rst_n = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Palette: random pool first, directed entries last so they are not overwritten
    pool[0] = 'h005;
    pool[1] = 'h105;
    pool[2] = 'h7FF;
    for (int i = 3; i < 16; i++) begin
      pool[i] = (i < 8) ? (($urandom_range(0, 127) << 4) | 'hF) : $urandom_range(0, 2047);
      cpu_wr(0, pool[i], $urandom_range(0, 65535));
      cpu_wr(1, pool[i], $urandom_range(0, 65535));
    end
    cpu_wr(0, 'h005, 'h0A3C);
    cpu_wr(1, 'h005, 'h0C53);
    cpu_wr(0, 'h105, 'h0123);
    cpu_wr(1, 'h105, 'h0456);
    cpu_wr(0, 'h7FF, 'h7FFF);
    cpu_wr(1, 'h7FF, 'h1234);

    cpu_chk(0, 'h005, 0);
    cpu_chk(0, 'h005, 1);
    cpu_chk(1, 'h005, 0);
    cpu_chk(1, 'h7FF, 1);

    pal_bank = '0;
    model_reset();

    // Directed priority / blanking table
    tbl[0] = '{lp('h005, 'h105, 'h7FF), 3'b111, 1'b1, 1'b1, 'h005};
    tbl[1] = '{lp('h00F, 'h105, 'h7FF), 3'b111, 1'b1, 1'b1, 'h105};
    tbl[2] = '{lp('h005, 'h105, 'h7FF), 3'b110, 1'b1, 1'b1, 'h105};
    tbl[3] = '{lp('h01F, 'h02F, 'h7FF), 3'b111, 1'b1, 1'b1, 'h7FF};
    tbl[4] = '{lp('h005, 'h105, 'h7FF), 3'b000, 1'b1, 1'b1, 'h7FF};
    tbl[5] = '{lp('h01F, 'h02F, 'h105), 3'b111, 1'b1, 1'b1, 'h105};
    tbl[6] = '{lp('h01F, 'h105, 'h005), 3'b101, 1'b1, 1'b1, 'h005};
    tbl[7] = '{lp('h005, 'h105, 'h7FF), 3'b111, 1'b0, 1'b1, 'h005};
    tbl[8] = '{lp('h105, 'h005, 'h7FF), 3'b111, 1'b1, 1'b0, 'h105};
    tbl[9] = '{lp('h7FF, 'h7FF, 'h7FF), 3'b111, 1'b1, 1'b1, 'h7FF};
    for (int i = 0; i < 10; i++)
      px(tbl[i].p, tbl[i].en, tbl[i].hb, tbl[i].vb, 4, tbl[i].entry, $sformatf("tbl%0d", i));

    // Bank request mid-frame takes effect only after LVBL falls
    pal_bank = 1'b1;
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "bank_pre0");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "bank_pre1");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b0, 4, -1, "bank_vbf");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b0, 4, -1, "bank_vb");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "bank_post0");
    px(lp('h105, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "bank_post1");

    // Pixel spacing: exactly 3 clocks, then a too-early pixel
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 3, -1, "gap3");
    px(lp('h105, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "gap4");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 2, -1, "early");
    px(lp('h7FF, 'h7FF, 'h7FF), 3'b111, 1'b1, 1'b1, 4, -1, "after_early");
    px(lp('h105, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "recover");

    // Randomized pixels, enables, blanking, bank requests and spacing
    for (int i = 0; i < 300; i++) begin
      bit hb, vb;
      if ($urandom_range(0, 19) == 0) pal_bank = BW'($urandom_range(0, 1));
      hb = ($urandom_range(0, 9) != 0);
      vb = ((i % 50) < 45);
      px(lp(pool[$urandom_range(0, 15)], pool[$urandom_range(0, 15)], pool[$urandom_range(0, 15)]),
         3'($urandom_range(0, 7)), hb, vb, $urandom_range(2, 5), -1, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-line with visible colour on the outputs
    pal_bank = 1'b1;
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "pre_rst0");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "pre_rst1");
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "post_rst0");
    px(lp('h005, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "post_rst1");
    px(lp('h105, 0, 0), 3'b001, 1'b1, 1'b1, 4, -1, "post_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
